// File: rtl/adder_pipe_pkg.sv
// Shared constants and elaboration helpers for the segmented pipelined adder.
package adder_pipe_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int seg_width(input int width, input int stages);
      return width / stages;
   endfunction

   function automatic int pipe_latency(input int stages);
      return stages + 1;
   endfunction

endpackage

// File: rtl/adder_segment.sv
// One carry segment of the pipelined adder: registered SEG-bit sum plus carry-out.
module adder_segment #(
   parameter int SEG = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           enable,
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           carry_in,
   output logic [SEG-1:0] sum,
   output logic           carry_out
);

   logic [SEG:0] res_d;
   logic [SEG:0] res_q;

   always_comb begin
      res_d = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, carry_in};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         res_q <= '0;
      end else if (enable) begin
         res_q <= res_d;
      end
   end

   assign sum       = res_q[SEG-1:0];
   assign carry_out = res_q[SEG];

endmodule

// File: rtl/pipelined_segmented_adder.sv
// Add/subtract with the carry chain split into STAGES registered segments and a global-stall handshake.
// Optional signed-overflow output ovf is enabled by defining ADDER_OVERFLOW_FLAG_EN.
module pipelined_segmented_adder
   import adder_pipe_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef ADDER_OVERFLOW_FLAG_EN
   output logic             ovf,
`endif
   output logic [WIDTH:0]   sum
);

   localparam int SEG = seg_width(WIDTH, STAGES);

   logic                 adv;
   logic [WIDTH-1:0]     opa_d [STAGES];
   logic [WIDTH-1:0]     opa_q [STAGES];
   logic [WIDTH-1:0]     opb_d [STAGES];
   logic [WIDTH-1:0]     opb_q [STAGES];
   logic [STAGES:0]      vld_d;
   logic [STAGES:0]      vld_q;
   logic                 cin_d;
   logic                 cin_q;
   logic [WIDTH-1:0]     low_d [1:STAGES];
   logic [WIDTH-1:0]     low_q [1:STAGES];
   logic [WIDTH-1:0]     res_w [1:STAGES];
   logic [SEG-1:0]       seg_sum [1:STAGES];
   logic [STAGES:0]      carry_w;

   always_comb begin
      adv      = !vld_q[STAGES] || out_ready;
      opa_d[0] = a;
      opb_d[0] = (sub == OP_SUB) ? ~b : b;
      cin_d    = (sub == OP_SUB);
      vld_d[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         opa_d[k] = opa_q[k-1];
         opb_d[k] = opb_q[k-1];
      end
      for (int k = 1; k <= STAGES; k++) begin
         vld_d[k] = vld_q[k-1];
      end
      low_d[1] = '0;
      for (int k = 2; k <= STAGES; k++) begin
         low_d[k] = res_w[k-1];
      end
   end

   // Operand delay line: data only, no reset needed
   always_ff @(posedge clk) begin
      if (adv) begin
         opa_q <= opa_d;
         opb_q <= opb_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= '0;
         cin_q <= 1'b0;
         for (int k = 1; k <= STAGES; k++) begin
            low_q[k] <= '0;
         end
      end else if (adv) begin
         vld_q <= vld_d;
         cin_q <= cin_d;
         low_q <= low_d;
      end
   end

   assign carry_w[0] = cin_q;

   // Stage k adds segment k-1 and merges it above the already-finished lower segments
   for (genvar k = 1; k <= STAGES; k++) begin : g_stage
      adder_segment #(.SEG(SEG)) u_seg (
         .clk       (clk),
         .reset     (reset),
         .enable    (adv),
         .a         (opa_q[k-1][(k-1)*SEG +: SEG]),
         .b         (opb_q[k-1][(k-1)*SEG +: SEG]),
         .carry_in  (carry_w[k-1]),
         .sum       (seg_sum[k]),
         .carry_out (carry_w[k])
      );
      assign res_w[k] = low_q[k] | (WIDTH'(seg_sum[k]) << ((k-1)*SEG));
   end

   assign in_ready  = adv;
   assign out_valid = vld_q[STAGES];
   assign sum       = {carry_w[STAGES], res_w[STAGES]};

`ifdef ADDER_OVERFLOW_FLAG_EN
   logic [SEG-1:0] a_top;
   logic [SEG-1:0] b_top;
   logic           cmsb_d;
   logic           cmsb_q;

   assign a_top = opa_q[STAGES-1][WIDTH-1 -: SEG];
   assign b_top = opb_q[STAGES-1][WIDTH-1 -: SEG];

   // Carry into the MSB is captured alongside the top segment so ovf lines up with sum
   if (SEG == 1) begin : g_cmsb_bit
      assign cmsb_d = carry_w[STAGES-1];
   end else begin : g_cmsb_seg
      logic [SEG-1:0] low_sum;
      assign low_sum = {1'b0, a_top[SEG-2:0]} + {1'b0, b_top[SEG-2:0]}
                     + {{(SEG-1){1'b0}}, carry_w[STAGES-1]};
      assign cmsb_d  = low_sum[SEG-1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cmsb_q <= 1'b0;
      end else if (adv) begin
         cmsb_q <= cmsb_d;
      end
   end

   assign ovf = cmsb_q ^ carry_w[STAGES];
`endif

endmodule

// File: tb/tb_pipelined_segmented_adder.sv
// Self-checking bench for pipelined_segmented_adder: vector table plus stall and reset sequences.
module tb_pipelined_segmented_adder;
   import adder_pipe_pkg::*;

   localparam int WIDTH = 32;
   parameter int STAGES = 4;
   localparam int LAT = pipe_latency(STAGES);

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   sum;
`ifdef ADDER_OVERFLOW_FLAG_EN
   logic             ovf;
`endif

   always #5 clk = ~clk;

   pipelined_segmented_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef ADDER_OVERFLOW_FLAG_EN
      .ovf       (ovf),
`endif
      .sum       (sum)
   );

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             sub;
      logic [WIDTH:0]   sum;
      logic             ovf;
   } vec_t;

   typedef struct {
      logic [WIDTH:0] sum;
      logic           ovf;
      int             cyc;
      bit             lat;
   } exp_t;

   exp_t           sb[$];
   int             n_vec = 0;
   int             n_mis = 0;
   int             cyc = 0;
   bit             lat_chk = 1'b1;
   logic [WIDTH:0] cur_sum = '0;
   logic           cur_ovf = 1'b0;
   vec_t           tbl[10];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_mis++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Independent reference: subtraction as a - b with no-borrow flag
   function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic s);
      logic [WIDTH:0] r;
      logic           ov;
      if (s == OP_ADD) begin
         r  = {1'b0, x} + {1'b0, y};
         ov = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      end else begin
         r[WIDTH-1:0] = x - y;
         r[WIDTH]     = (x >= y);
         ov = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      end
      return {ov, r};
   endfunction

   // Scoreboard: push on input transfer, pop and compare on output transfer
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_mis++;
               $display("FAIL unexpected_out: got sum %0h with no beat outstanding (cycle %0d)", sum, cyc);
            end else begin
               e = sb.pop_front();
               chk("sum", 64'(sum), 64'(e.sum));
`ifdef ADDER_OVERFLOW_FLAG_EN
               chk("ovf", 64'(ovf), 64'(e.ovf));
`endif
               if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'(LAT));
            end
         end
         if (in_valid && in_ready) begin
            e.sum = cur_sum;
            e.ovf = cur_ovf;
            e.cyc = cyc;
            e.lat = lat_chk;
            sb.push_back(e);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vs,
                       input logic [WIDTH:0] es, input logic eo);
      int t;
      bit acc;
      a = va; b = vb; sub = vs; cur_sum = es; cur_ovf = eo; in_valid = 1'b1;
      t = 0; acc = 1'b0;
      while (!acc && t < 50) begin
         @(negedge clk);
         acc = in_ready;
         tick();
         t++;
      end
      if (!acc) begin
         n_vec++;
         n_mis++;
         $display("FAIL send_timeout: in_ready stayed 0, required 1 within 50 cycles");
      end
      in_valid = 1'b0;
   endtask

   task automatic send_model(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vs);
      logic [WIDTH+1:0] m;
      m = model(va, vb, vs);
      send(va, vb, vs, m[WIDTH:0], m[WIDTH+1]);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 4 * LAT + 20) begin
         tick();
         t++;
      end
      chk("drain_outstanding", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      logic [WIDTH:0] snap;
      logic [WIDTH+1:0] m;

      tbl[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 33'h1_0000_0000, 1'b0};
      tbl[1] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 33'h0_FFFF_FFFE, 1'b0};
      tbl[2] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 33'h1_0000_0002, 1'b0};
      tbl[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000, 1'b1};
      tbl[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 33'h1_0000_0000, 1'b0};
      tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33'h1_FFFF_FFFE, 1'b0};
      tbl[6] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 33'h1_7FFF_FFFF, 1'b1};
      tbl[7] = '{32'h1234_5678, 32'h0FED_CBA9, 1'b0, 33'h0_2222_2221, 1'b0};
      tbl[8] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 33'h0_0001_0000, 1'b0};
      tbl[9] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 33'h0_FFFF_FFFF, 1'b0};

      reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_sum", 64'(sum), 64'd0);
`ifdef ADDER_OVERFLOW_FLAG_EN
      chk("reset_ovf", 64'(ovf), 64'd0);
`endif
      tick();

      // Single isolated add: full carry ripple, fixed latency
      send(tbl[0].a, tbl[0].b, tbl[0].sub, tbl[0].sum, tbl[0].ovf);
      drain();

      // Whole table back-to-back
      for (int i = 0; i < 10; i++) send(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].sum, tbl[i].ovf);
      drain();

      // Stream a=i, b=2i
      for (int i = 0; i < 8; i++) send(WIDTH'(i), WIDTH'(2 * i), OP_ADD, (WIDTH + 1)'(3 * i), 1'b0);
      drain();

      // Stall with a result waiting, then release while a new beat is offered
      lat_chk = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send_model(WIDTH'(100 + i), WIDTH'(7 * i), (i == 1) ? OP_SUB : OP_ADD);
      t = 0;
      while (!out_valid && t < 4 * LAT + 10) begin
         tick();
         t++;
      end
      chk("stall_reached", 64'(out_valid), 64'd1);
      snap = sum;
      m = model(32'h0000_0010, 32'h0000_0020, OP_SUB);
      a = 32'h0000_0010; b = 32'h0000_0020; sub = OP_SUB;
      cur_sum = m[WIDTH:0]; cur_ovf = m[WIDTH+1]; in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("stall_out_valid", 64'(out_valid), 64'd1);
         chk("stall_in_ready", 64'(in_ready), 64'd0);
         chk("stall_sum", 64'(sum), 64'(snap));
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      drain();
      lat_chk = 1'b1;

      // Reset with three beats in flight
      for (int i = 0; i < 3; i++) send_model(WIDTH'(32'hABCD_0000 + i), WIDTH'(i), OP_ADD);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      repeat (2 * LAT) begin
         tick();
         @(negedge clk);
         chk("flush_idle_valid", 64'(out_valid), 64'd0);
      end
      tick();

      // Recovery after flush
      send(tbl[2].a, tbl[2].b, tbl[2].sub, tbl[2].sum, tbl[2].ovf);
      send(tbl[3].a, tbl[3].b, tbl[3].sub, tbl[3].sum, tbl[3].ovf);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
